axi_s2mm_ring: RTL
==================

AXI_S2MM_RING -- requirements
Module: axi_s2mm_ring

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 64: address width; command width is C_AXI_ADDR_WIDTH+16.
REQ-002 SHALL have parameter C_OCC_WIDTH, default 32: width of ring size, offset and occupancy values.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 enable  in  1  level; 1 allows new commands to be issued.
REQ-006 clear  in  1  pulse; zeroes wr_offset, occupancy and error while in IDLE.
REQ-007 cfg_base  in  C_AXI_ADDR_WIDTH  ring base byte address.
REQ-008 cfg_size  in  C_OCC_WIDTH  ring size in bytes; nonzero.
REQ-009 cfg_chunk  in  16  maximum bytes per command; nonzero.
REQ-010 rel_valid  in  1  pulse; consumer releases rel_bytes of ring space.
REQ-011 rel_bytes  in  16  bytes released.
REQ-012 m_axis_ctl_tdata  out  C_AXI_ADDR_WIDTH+16  command: [C_AXI_ADDR_WIDTH-1:0] = address, [C_AXI_ADDR_WIDTH+15:C_AXI_ADDR_WIDTH] = length in bytes.
REQ-013 m_axis_ctl_tvalid / m_axis_ctl_tready  out / in  1  AXI-Stream command handshake to the S2MM engine.
REQ-014 s_axis_st_tdata  in  8  status; bit 0 = 1 means the transfer failed; bits 7:1 are ignored.
REQ-015 s_axis_st_tvalid / s_axis_st_tready  in / out  1  status handshake.
REQ-016 wr_offset  out  C_OCC_WIDTH  committed write offset within the ring.
REQ-017 occupancy  out  C_OCC_WIDTH  committed bytes not yet released.
REQ-018 irq  out  1  one-cycle pulse per successful completion.
REQ-019 error  out  1  sticky failure flag.
REQ-020 busy  out  1  1 in any state other than IDLE.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, WAIT_ST and HALT.
REQ-022 Per cycle in IDLE: len = min(cfg_chunk, cfg_size - wr_offset); go to ISSUE when enable=1, error=0 and cfg_size - occupancy >= len.
REQ-023 On entering ISSUE: latch m_axis_ctl_tdata = {len, cfg_base + wr_offset}; assert tvalid; hold tdata and tvalid stable until tready.
REQ-024 ISSUE -> WAIT_ST on the cycle tvalid & tready; tvalid deasserts the next cycle; at most one command outstanding.
REQ-025 s_axis_st_tready SHALL be 1 only in WAIT_ST.
REQ-026 Status handshake with bit0 = 0:
- wr_offset += len; wraps to 0 when the result equals cfg_size.
- occupancy += len.
- irq pulses the next cycle.
- state -> IDLE.
REQ-027 Status handshake with bit0 = 1: error <= 1; wr_offset and occupancy unchanged; no irq; state -> HALT.
REQ-028 HALT SHALL exit to IDLE only on clear; clear also zeroes error.
REQ-029 Release: on rel_valid, occupancy -= rel_bytes, saturating at 0; accepted in every state.
REQ-030 Same-cycle successful completion and release: occupancy <= occupancy + len - rel_bytes, saturating at 0.
REQ-031 enable falling in ISSUE or WAIT_ST SHALL NOT abort the outstanding command; return to IDLE and stall there.
REQ-032 clear outside IDLE/HALT SHALL be ignored; clear in IDLE SHALL suppress command issue that cycle.
REQ-033 cfg_* SHALL be sampled only in IDLE; changes while busy take effect from the next IDLE.
REQ-034 When cfg_size is not a multiple of cfg_chunk, the command ending at the ring end SHALL be truncated (REQ-022); no command crosses the ring end.
REQ-035 Address addition SHALL be C_AXI_ADDR_WIDTH-bit modulo; offsets SHALL be zero-extended.

Reset
REQ-036 rst_n low SHALL asynchronously force:
- state = IDLE;
- m_axis_ctl_tvalid = 0, m_axis_ctl_tdata = 0;
- s_axis_st_tready = 0;
- wr_offset = 0, occupancy = 0;
- irq = 0, error = 0, busy = 0.
REQ-037 Reset mid-transfer SHALL drop the outstanding command state; a status arriving after reset SHALL NOT be accepted until WAIT_ST.

Verification
REQ-038 Setup: base=0x1000, size=0x300, chunk=0x100, enable=1, tready=1, status 0x00. Response: commands {0x100,0x1000}, {0x100,0x1100}, {0x100,0x1200}; then stall, occupancy=0x300, wr_offset=0, three irq pulses.
REQ-039 From REQ-038 end: release 0x100. Response: next command {0x100,0x1000}; occupancy 0x200 then 0x300.
REQ-040 Setup: size=0x250, chunk=0x100. Response: third command length 0x050 at 0x1200; wr_offset wraps to 0.
REQ-041 Status 0x01 on the second command. Response: error=1, HALT, busy=1, wr_offset=0x100, no irq. After clear: error=0, IDLE, wr_offset=0, occupancy=0.
REQ-042 Same-cycle success of 0x100 and release of 0x180 with occupancy 0x100. Response: occupancy 0x080. Release of 0x200 with occupancy 0x080. Response: occupancy 0.
REQ-043 tready held low 5 cycles. Response: tdata stable, tvalid=1 throughout. Then enable drops in WAIT_ST. Response: status still accepted, returns to IDLE, no further command issued.

Source files
------------

// File: rtl/axi_s2mm_ring.sv
// Ring-buffer command generator for an AXI S2MM engine. It issues one
// chunked write command at a time and tracks the write offset and occupancy.
module axi_s2mm_ring #(
    parameter int C_AXI_ADDR_WIDTH = 64,
    parameter int C_OCC_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   cfg_base,
    input  logic [C_OCC_WIDTH-1:0]        cfg_size,
    input  logic [15:0]                   cfg_chunk,
    input  logic                          rel_valid,
    input  logic [15:0]                   rel_bytes,
    output logic [C_AXI_ADDR_WIDTH+15:0]  m_axis_ctl_tdata,
    output logic                          m_axis_ctl_tvalid,
    input  logic                          m_axis_ctl_tready,
    input  logic [7:0]                    s_axis_st_tdata,
    input  logic                          s_axis_st_tvalid,
    output logic                          s_axis_st_tready,
    output logic [C_OCC_WIDTH-1:0]        wr_offset,
    output logic [C_OCC_WIDTH-1:0]        occupancy,
    output logic                          irq,
    output logic                          error,
    output logic                          busy
);

    localparam int OCC1 = C_OCC_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ST, HALT} state_t;

    state_t                         state_reg;
    logic [C_AXI_ADDR_WIDTH+15:0]   tdata_reg;
    logic                           tvalid_reg;
    logic                           st_tready_reg;
    logic [C_OCC_WIDTH-1:0]         wr_offset_reg;
    logic [C_OCC_WIDTH-1:0]         occupancy_reg;
    logic [C_OCC_WIDTH-1:0]         size_reg;
    logic [15:0]                    len_reg;
    logic                           irq_reg;
    logic                           error_reg;
    logic                           busy_reg;

    logic [C_OCC_WIDTH-1:0]         remain;
    logic [C_OCC_WIDTH-1:0]         room;
    logic [15:0]                    len_next;
    logic                           can_issue;
    logic                           st_ok;
    logic [OCC1-1:0]                occ_add;
    logic [OCC1-1:0]                occ_sat;
    logic [C_OCC_WIDTH-1:0]         occupancy_next;
    logic [C_OCC_WIDTH-1:0]         offset_sum;
    logic [C_OCC_WIDTH-1:0]         wr_offset_next;
    logic                           unused_st_bits;

    // Truncate the command so it never runs past the end of the ring.
    assign remain    = cfg_size - wr_offset_reg;
    assign len_next  = (remain < C_OCC_WIDTH'(cfg_chunk)) ? 16'(remain) : cfg_chunk;
    assign room      = cfg_size - occupancy_reg;
    assign can_issue = enable && !error_reg && !clear && (room >= C_OCC_WIDTH'(len_next));

    // Completion and release may coincide; add first, then saturate the subtraction.
    assign st_ok   = (state_reg == WAIT_ST) && s_axis_st_tvalid && !s_axis_st_tdata[0];
    assign occ_add = {1'b0, occupancy_reg} + (st_ok ? OCC1'(len_reg) : {OCC1{1'b0}});
    assign occ_sat = !rel_valid                    ? occ_add :
                     (occ_add >= OCC1'(rel_bytes)) ? occ_add - OCC1'(rel_bytes) :
                                                     {OCC1{1'b0}};
    assign occupancy_next = occ_sat[C_OCC_WIDTH-1:0];

    // Wrap against the size captured when the command was issued.
    assign offset_sum     = wr_offset_reg + C_OCC_WIDTH'(len_reg);
    assign wr_offset_next = (offset_sum == size_reg) ? '0 : offset_sum;

    assign unused_st_bits = ^s_axis_st_tdata[7:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            st_tready_reg <= 1'b0;
            wr_offset_reg <= '0;
            occupancy_reg <= '0;
            size_reg      <= '0;
            len_reg       <= '0;
            irq_reg       <= 1'b0;
            error_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            irq_reg       <= 1'b0;
            occupancy_reg <= occupancy_next;
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        wr_offset_reg <= '0;
                        occupancy_reg <= '0;
                        error_reg     <= 1'b0;
                    end else if (can_issue) begin
                        tdata_reg  <= {len_next, cfg_base + C_AXI_ADDR_WIDTH'(wr_offset_reg)};
                        tvalid_reg <= 1'b1;
                        len_reg    <= len_next;
                        size_reg   <= cfg_size;
                        busy_reg   <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_axis_ctl_tready) begin
                        tvalid_reg    <= 1'b0;
                        st_tready_reg <= 1'b1;
                        state_reg     <= WAIT_ST;
                    end
                end
                WAIT_ST: begin
                    if (s_axis_st_tvalid) begin
                        st_tready_reg <= 1'b0;
                        if (s_axis_st_tdata[0]) begin
                            error_reg <= 1'b1;
                            state_reg <= HALT;
                        end else begin
                            wr_offset_reg <= wr_offset_next;
                            irq_reg       <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (clear) begin
                        wr_offset_reg <= '0;
                        occupancy_reg <= '0;
                        error_reg     <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis_ctl_tdata  = tdata_reg;
    assign m_axis_ctl_tvalid = tvalid_reg;
    assign s_axis_st_tready  = st_tready_reg;
    assign wr_offset         = wr_offset_reg;
    assign occupancy         = occupancy_reg;
    assign irq               = irq_reg;
    assign error             = error_reg;
    assign busy              = busy_reg;

endmodule
